c2h_pkt_arbiter: RTL
====================

C2H_PKT_ARBITER -- requirements
Module: c2h_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_Q, default 4, number of traffic-generator requesters (2..8).
REQ-002 SHALL have parameter RX_LEN, default 512, stream data width in bits.
REQ-003 SHALL have parameter RX_BEN, default RX_LEN/8, byte-enable width.
REQ-004 SHALL have parameter TM_DSC_BITS, default 16, credit counter width.
REQ-005 SHALL have port axi_aclk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port axi_aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  permits new grants when high.
REQ-008 SHALL have port credit_in  input  TM_DSC_BITS  credits to add.
REQ-009 SHALL have port credit_qid  input  $clog2(NUM_Q)  queue receiving credit_in.
REQ-010 SHALL have port credit_updt  input  1  credit_in valid strobe.
REQ-011 SHALL have port s_valid  input  NUM_Q  per-requester beat valid.
REQ-012 SHALL have port s_ready  output  NUM_Q  per-requester beat ready.
REQ-013 SHALL have port s_data  input  NUM_Q*RX_LEN  requester data, requester i at [i*RX_LEN +: RX_LEN].
REQ-014 SHALL have port s_ben  input  NUM_Q*RX_BEN  requester byte enables, same packing.
REQ-015 SHALL have port s_last  input  NUM_Q  per-requester end of frame.
REQ-016 SHALL have port m_valid/m_ready/m_data/m_ben/m_last  out/in/out/out/out  1/1/RX_LEN/RX_BEN/1  shared C2H stream.
REQ-017 SHALL have port m_qid  output  $clog2(NUM_Q)  index of granted requester.
REQ-018 SHALL have port credit_cnt  output  NUM_Q*TM_DSC_BITS  current per-queue credits.
REQ-019 SHALL have port frame_cnt  output  32  total frames forwarded, wraps at 2^32.

Function
REQ-020 SHALL keep one credit counter per queue; one credit = one frame (s_last-terminated).
REQ-021 SHALL add credit_in to counter[credit_qid] on credit_updt, saturating at 2^TM_DSC_BITS-1.
REQ-022 SHALL subtract 1 from the granted queue counter on the cycle m_valid&m_ready&m_last.
REQ-023 SHALL apply add and subtract on the same queue in the same cycle as net (count+credit_in-1), saturating.
REQ-024 SHALL treat queue i as eligible when s_valid[i]=1 and counter[i]>0.
REQ-025 SHALL implement states IDLE, ARB, XFER.
REQ-026 IDLE: go to ARB when enable=1; else stay.
REQ-027 ARB: when any queue is eligible, grant the first eligible queue searching from last_grant+1 modulo NUM_Q, register it in gnt, and go to XFER; else stay (return to IDLE if enable=0).
REQ-028 SHALL set last_grant to 0 after reset (so queue 1 has first priority) and update it on every grant.
REQ-029 XFER: m_valid=s_valid[gnt], m_data/m_ben/m_last from requester gnt, s_ready[gnt]=m_ready, and all other s_ready=0 (combinational pass-through, zero added latency).
REQ-030 XFER: on m_valid&m_ready&m_last, increment frame_cnt and go to ARB if enable=1, else IDLE.
REQ-031 SHALL hold the grant for the whole frame; enable deasserted mid-frame SHALL NOT truncate it.
REQ-032 Outside XFER: m_valid=0, m_last=0, s_ready=0, m_data/m_ben=0.
REQ-033 Grant latency SHALL be 1 cycle from ARB with an eligible queue to first beat presentable in XFER.
REQ-034 A queue whose counter reaches 0 after its frame SHALL NOT be granted until credit is added.
REQ-035 m_qid SHALL equal gnt in XFER and 0 otherwise.

Reset
REQ-036 On axi_aresetn=0 (asynchronous, any state, including mid-frame): state=IDLE, all credit counters=0, frame_cnt=0, gnt=0, last_grant=0, all outputs 0.
REQ-037 After reset release, first grant SHALL NOT occur before the second rising edge.

Verification
REQ-038 Single queue: credit 3 to q0, q0 sends 3 frames of 4 beats, m_ready=1 -> 12 beats out with m_qid=0, frame_cnt=3, credit_cnt q0=0, 4th frame stalled (s_ready[0]=0).
REQ-039 Round robin: all 4 queues credited 2 and valid continuously -> grant order 1,2,3,0,1,2,3,0, then no grants.
REQ-040 Backpressure: m_ready toggles 1010 mid-frame -> no beat lost or duplicated, s_ready[gnt] mirrors m_ready, m_last only on final beat.
REQ-041 Simultaneous credit: credit_updt with credit_in=5 to q2 on the same cycle q2 completes a frame from count 1 -> count becomes 5.
REQ-042 Enable drop: enable=0 on 2nd beat of a 4-beat frame -> frame completes, state IDLE, no further grants until enable=1.
REQ-043 Reset mid-frame: axi_aresetn=0 during beat 2 -> m_valid, s_ready drop immediately, all credits read 0 after release.

Source files
------------

// File: rtl/c2h_pkt_arbiter.sv
// rtl/c2h_pkt_arbiter.sv - credit-gated round-robin arbiter merging per-queue frame streams onto one C2H stream
module c2h_pkt_arbiter #(
  parameter int NUM_Q       = 4,
  parameter int RX_LEN      = 512,
  parameter int RX_BEN      = RX_LEN/8,
  parameter int TM_DSC_BITS = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          enable,
  input  logic [TM_DSC_BITS-1:0]        credit_in,
  input  logic [$clog2(NUM_Q)-1:0]      credit_qid,
  input  logic                          credit_updt,
  input  logic [NUM_Q-1:0]              s_valid,
  output logic [NUM_Q-1:0]              s_ready,
  input  logic [NUM_Q*RX_LEN-1:0]       s_data,
  input  logic [NUM_Q*RX_BEN-1:0]       s_ben,
  input  logic [NUM_Q-1:0]              s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [RX_LEN-1:0]             m_data,
  output logic [RX_BEN-1:0]             m_ben,
  output logic                          m_last,
  output logic [$clog2(NUM_Q)-1:0]      m_qid,
  output logic [NUM_Q*TM_DSC_BITS-1:0]  credit_cnt,
  output logic [31:0]                   frame_cnt
);

  localparam int QW = $clog2(NUM_Q);
  localparam logic [TM_DSC_BITS:0] CRED_MAX = {1'b0, {TM_DSC_BITS{1'b1}}};
  localparam logic [TM_DSC_BITS:0] CRED_ONE = {{TM_DSC_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t                  state, state_nxt;
  logic [QW-1:0]           gnt, last_grant, pick_idx;
  logic                    pick_found, xfer_done;
  logic [NUM_Q-1:0]        elig;
  logic [TM_DSC_BITS-1:0]  credit     [NUM_Q];
  logic [TM_DSC_BITS-1:0]  credit_nxt [NUM_Q];
  logic [TM_DSC_BITS:0]    credit_sum [NUM_Q];

  assign xfer_done = (state == XFER) && s_valid[gnt] && m_ready && s_last[gnt];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = s_valid[i] && (credit[i] != '0);
    end
  end

  // Rotating search starts one past the previous winner so every queue gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_Q; k++) begin
      if (!pick_found && elig[(int'(last_grant) + k) % NUM_Q]) begin
        pick_found = 1'b1;
        pick_idx   = QW'((int'(last_grant) + k) % NUM_Q);
      end
    end
  end

  // Add and end-of-frame subtract on the same queue combine before saturation.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      credit_sum[i] = {1'b0, credit[i]};
      if (credit_updt && (credit_qid == QW'(i))) begin
        credit_sum[i] = credit_sum[i] + {1'b0, credit_in};
      end
      if (xfer_done && (gnt == QW'(i)) && (credit_sum[i] != '0)) begin
        credit_sum[i] = credit_sum[i] - CRED_ONE;
      end
      credit_nxt[i] = (credit_sum[i] > CRED_MAX) ? CRED_MAX[TM_DSC_BITS-1:0]
                                                 : credit_sum[i][TM_DSC_BITS-1:0];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_data    = '0;
    m_ben     = '0;
    m_last    = 1'b0;
    m_qid     = '0;
    s_ready   = '0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ARB;
      end
      ARB: begin
        if (pick_found)   state_nxt = XFER;
        else if (!enable) state_nxt = IDLE;
      end
      XFER: begin
        m_valid      = s_valid[gnt];
        m_data       = s_data[int'(gnt)*RX_LEN +: RX_LEN];
        m_ben        = s_ben[int'(gnt)*RX_BEN +: RX_BEN];
        m_last       = s_last[gnt];
        m_qid        = gnt;
        s_ready[gnt] = m_ready;
        if (xfer_done) state_nxt = enable ? ARB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      gnt        <= '0;
      last_grant <= '0;
      frame_cnt  <= '0;
      for (int i = 0; i < NUM_Q; i++) credit[i] <= '0;
    end else begin
      if ((state == ARB) && pick_found) begin
        gnt        <= pick_idx;
        last_grant <= pick_idx;
      end
      if (xfer_done) frame_cnt <= frame_cnt + 32'd1;
      for (int i = 0; i < NUM_Q; i++) credit[i] <= credit_nxt[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_Q; g++) begin : g_cnt
      assign credit_cnt[g*TM_DSC_BITS +: TM_DSC_BITS] = credit[g];
    end
  endgenerate

endmodule
